// File: rtl/req_pending_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : req_pending_latch_pkg
//  Description : Shared encoder definitions for the request-pending stage and
//                the downstream 4-input priority encoder. Holds the encoder
//                width, the index width, and the bit-to-letter map
//                (pend[3]=a is the highest priority).
//  Revision    : 1.0 - initial release
// ============================================================================
package req_pending_latch_pkg;

  localparam int ENC_N     = 4;
  localparam int ENC_IDX_W = 2;

  // Encoder input letters and the pend bit index that drives each one.
  typedef enum logic [ENC_IDX_W-1:0] {
    IDX_D = 2'd0,
    IDX_C = 2'd1,
    IDX_B = 2'd2,
    IDX_A = 2'd3
  } enc_letter_e;

endpackage : req_pending_latch_pkg
`default_nettype wire

// File: rtl/req_pending_latch_if.sv
`default_nettype none
// ============================================================================
//  Module      : req_pending_latch_if
//  Description : Request / acknowledge bundle between the request source,
//                the pending latch and the priority-encoder consumer.
//                slave  : seen by the pending latch (requests, mask, ack in;
//                         pend, pend_any, overflow out)
//                master : seen by whoever drives requests and acknowledges
//  Revision    : 1.0 - initial release
// ============================================================================
interface req_pending_latch_if
  import req_pending_latch_pkg::*;
#(
  parameter int N = ENC_N
) ();

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req_in;     // raw asynchronous request lines
  logic [N-1:0]     mask;       // 1 = hide pending bit from pend
  logic             ack_valid;  // consumer acknowledges ack_idx this cycle
  logic [IDX_W-1:0] ack_idx;    // index being acknowledged
  logic             clr_ovf;    // clear all overflow bits
  logic [N-1:0]     pend;       // pend_raw & ~mask, to encoder a..d
  logic             pend_any;   // |pend
  logic [N-1:0]     overflow;   // sticky per-bit overflow

  modport slave (
    input  req_in, mask, ack_valid, ack_idx, clr_ovf,
    output pend, pend_any, overflow
  );

  modport master (
    output req_in, mask, ack_valid, ack_idx, clr_ovf,
    input  pend, pend_any, overflow
  );

endinterface : req_pending_latch_if
`default_nettype wire

// File: rtl/req_pending_latch_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : req_pending_latch_sync_bit
//  Description : Single-bit multi-flop synchroniser for one asynchronous
//                request line. All flops clear asynchronously on rst.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous reset, active high
//                d_i  - raw asynchronous input
//                q_o  - synchronised output (last flop of the chain)
//  Revision    : 1.0 - initial release
// ============================================================================
module req_pending_latch_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : req_pending_latch_sync_bit
`default_nettype wire

// File: rtl/req_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module      : req_pending_latch
//  Description : Upstream stage of the 4-input priority encoder. Synchronises
//                asynchronous request lines, captures each request event in
//                a sticky pending bit and holds it until the consumer
//                acknowledges that index. Tracks per-bit overflow when a new
//                event arrives for a bit that is still pending.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous reset, active high
//                bus  - req_pending_latch_if.slave
//                       in : req_in, mask, ack_valid, ack_idx, clr_ovf
//                       out: pend, pend_any, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module req_pending_latch
  import req_pending_latch_pkg::*;
#(
  parameter int N           = ENC_N,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  req_pending_latch_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] w_req_s;      // synchronised requests
  logic [N-1:0] req_dly_q;    // w_req_s delayed one clock, for edge detect
  logic [N-1:0] pend_raw_q;
  logic [N-1:0] pend_raw_d;
  logic [N-1:0] overflow_q;
  logic [N-1:0] overflow_d;
  logic [N-1:0] w_set;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_ovf_evt;

  for (genvar gi = 0; gi < N; gi++) begin : g_sync
    req_pending_latch_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.req_in[gi]),
      .q_o (w_req_s[gi])
    );
  end

  always_comb begin
    w_set = EDGE ? (w_req_s & ~req_dly_q) : w_req_s;

    // Out-of-range indices simply match no bit.
    w_clr = '0;
    for (int i = 0; i < N; i++) begin
      w_clr[i] = bus.ack_valid & (bus.ack_idx == IDX_W'(i));
    end

    // Only a fresh rise counts as an overflow, so a level-mode request held
    // high does not keep flagging. A same-cycle ack absorbs the new event.
    w_ovf_evt = w_set & pend_raw_q & ~w_clr & ~req_dly_q;

    // Set wins over a simultaneous clear on the same bit.
    pend_raw_d = (pend_raw_q & ~w_clr) | w_set;

    // A new overflow event wins over clr_ovf in the same cycle.
    overflow_d = bus.clr_ovf ? w_ovf_evt : (overflow_q | w_ovf_evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_dly_q  <= '0;
      pend_raw_q <= '0;
      overflow_q <= '0;
    end else begin
      req_dly_q  <= w_req_s;
      pend_raw_q <= pend_raw_d;
      overflow_q <= overflow_d;
    end
  end

  // Mask only hides bits from the encoder; latching continues underneath.
  assign bus.pend     = pend_raw_q & ~bus.mask;
  assign bus.pend_any = |(pend_raw_q & ~bus.mask);
  assign bus.overflow = overflow_q;

endmodule : req_pending_latch
`default_nettype wire

// File: tb/tb_req_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_pending_latch
//  Description : Directed self-checking bench for req_pending_latch
//                (N=4, SYNC_STAGES=2, EDGE=1). Observed vector is
//                {pend[3:0], pend_any, overflow[3:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_pending_latch;

  logic clk;
  logic rst;

  req_pending_latch_if #(.N(4)) bus ();

  req_pending_latch #(
    .N           (4),
    .SYNC_STAGES (2),
    .EDGE        (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int fail_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {bus.pend, bus.pend_any, bus.overflow};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_in    = 4'b0000;
    bus.mask      = 4'b0000;
    bus.ack_valid = 1'b0;
    bus.ack_idx   = 2'd0;
    bus.clr_ovf   = 1'b0;
    tick(3);
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL reset_held: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      tests_run++;
      if (obs() !== 9'b0000_0_0000) begin
        fail_cnt++;
        $display("FAIL reset_idle cyc%0d: got %b expected %b", c, obs(), 9'b0000_0_0000);
      end
    end
  endtask

  task automatic test_pulse_ack();
    bus.req_in = 4'b0100;
    tick(2);
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL pulse_latency: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    tick(1);
    tests_run++;
    if (obs() !== 9'b0100_1_0000) begin
      fail_cnt++;
      $display("FAIL pulse_set: got %b expected %b", obs(), 9'b0100_1_0000);
    end
    bus.req_in = 4'b0000;
    tick(4);
    tests_run++;
    if (obs() !== 9'b0100_1_0000) begin
      fail_cnt++;
      $display("FAIL pulse_sticky: got %b expected %b", obs(), 9'b0100_1_0000);
    end
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 2'd2;
    tick(1);
    bus.ack_valid = 1'b0;
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL pulse_ack: got %b expected %b", obs(), 9'b0000_0_0000);
    end
  endtask

  task automatic test_overflow();
    bus.req_in = 4'b0100;
    tick(3);
    bus.req_in = 4'b0000;
    tick(3);
    bus.req_in = 4'b0100;
    tick(3);
    tests_run++;
    if (obs() !== 9'b0100_1_0100) begin
      fail_cnt++;
      $display("FAIL ovf_set: got %b expected %b", obs(), 9'b0100_1_0100);
    end
    bus.req_in = 4'b0000;
    tick(4);
    tests_run++;
    if (obs() !== 9'b0100_1_0100) begin
      fail_cnt++;
      $display("FAIL ovf_sticky: got %b expected %b", obs(), 9'b0100_1_0100);
    end
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    tests_run++;
    if (obs() !== 9'b0100_1_0000) begin
      fail_cnt++;
      $display("FAIL ovf_clear: got %b expected %b", obs(), 9'b0100_1_0000);
    end
    // Fresh rise reaches the edge detector during the third cycle; clr_ovf
    // asserted for that same edge must lose to the new event.
    bus.req_in = 4'b0100;
    tick(2);
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    tests_run++;
    if (obs() !== 9'b0100_1_0100) begin
      fail_cnt++;
      $display("FAIL ovf_event_beats_clr: got %b expected %b", obs(), 9'b0100_1_0100);
    end
    bus.req_in    = 4'b0000;
    bus.clr_ovf   = 1'b1;
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 2'd2;
    tick(1);
    bus.clr_ovf   = 1'b0;
    bus.ack_valid = 1'b0;
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL ovf_cleanup: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    tick(3);
  endtask

  task automatic test_ack_set_same_cycle();
    bus.req_in = 4'b1000;
    tick(3);
    bus.req_in = 4'b0000;
    tick(3);
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 2'd2;
    tick(1);
    bus.ack_valid = 1'b0;
    tests_run++;
    if (obs() !== 9'b1000_1_0000) begin
      fail_cnt++;
      $display("FAIL ack_other_idx: got %b expected %b", obs(), 9'b1000_1_0000);
    end
    bus.req_in = 4'b1000;
    tick(2);
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 2'd3;
    tick(1);
    bus.ack_valid = 1'b0;
    tests_run++;
    if (obs() !== 9'b1000_1_0000) begin
      fail_cnt++;
      $display("FAIL ack_set_collide: got %b expected %b", obs(), 9'b1000_1_0000);
    end
    bus.req_in = 4'b0000;
    tick(3);
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 2'd3;
    tick(1);
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL ack_idx3: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    bus.ack_idx = 2'd1;
    tick(1);
    bus.ack_valid = 1'b0;
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL ack_not_pending: got %b expected %b", obs(), 9'b0000_0_0000);
    end
  endtask

  task automatic test_mask();
    bus.mask   = 4'b0010;
    bus.req_in = 4'b0010;
    tick(3);
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL mask_hidden: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    bus.mask = 4'b0000;
    #1;
    tests_run++;
    if (obs() !== 9'b0010_1_0000) begin
      fail_cnt++;
      $display("FAIL mask_exposed: got %b expected %b", obs(), 9'b0010_1_0000);
    end
    bus.mask      = 4'b0010;
    bus.ack_valid = 1'b1;
    bus.ack_idx   = 2'd1;
    tick(1);
    bus.ack_valid = 1'b0;
    bus.mask      = 4'b0000;
    #1;
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL mask_ack_masked: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    bus.req_in = 4'b0000;
    tick(3);
  endtask

  task automatic test_async_reset();
    bus.req_in = 4'b1110;
    tick(3);
    tests_run++;
    if (obs() !== 9'b1110_1_0000) begin
      fail_cnt++;
      $display("FAIL arst_setup: got %b expected %b", obs(), 9'b1110_1_0000);
    end
    bus.req_in = 4'b0001;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL arst_immediate: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    #1;
    rst = 1'b0;
    tick(2);
    tests_run++;
    if (obs() !== 9'b0000_0_0000) begin
      fail_cnt++;
      $display("FAIL arst_latency: got %b expected %b", obs(), 9'b0000_0_0000);
    end
    tick(1);
    tests_run++;
    if (obs() !== 9'b0001_1_0000) begin
      fail_cnt++;
      $display("FAIL arst_held_req: got %b expected %b", obs(), 9'b0001_1_0000);
    end
  endtask

  initial begin
    test_reset();
    test_pulse_ack();
    test_overflow();
    test_ack_set_same_cycle();
    test_mask();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule : tb_req_pending_latch
`default_nettype wire
